// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART write channel between NUM_REQ byte
// streams, with a stall timeout that revokes the grant from an owner that stops sending.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TIMEOUT = 4096,
    localparam int unsigned GW = $clog2(NUM_REQ)
) (
    input  logic                 uart_clk,
    input  logic                 uart_rst,
    input  logic                 uart_ready,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           uart_wr_data,
    output logic                 uart_wr_valid,
    input  logic                 uart_wr_ready,
    output logic [GW-1:0]        grant_id,
    output logic                 busy,
    output logic                 timeout_pulse
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_XFER = 1'b1;
    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [0:0]    r_state, w_state_d;
    logic [GW-1:0] r_grant, w_grant_d;
    logic [GW-1:0] r_last_grant, w_last_grant_d;
    logic [CW-1:0] r_cnt, w_cnt_d, w_cnt_inc;
    logic          r_pulse, w_pulse_d;
    logic [GW-1:0] w_pick, w_idx;
    logic          w_found;
    logic          w_own_valid, w_xfer;

    // Search starts one past the previous owner so every requester gets its turn.
    always_comb begin
        w_pick  = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            w_idx = GW'((32'(r_last_grant) + k) % NUM_REQ);
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    assign w_own_valid = req_valid[r_grant];
    assign w_xfer      = (r_state == ST_XFER) && w_own_valid && uart_wr_ready;
    assign w_cnt_inc   = (r_cnt == CW'(TIMEOUT)) ? r_cnt : r_cnt + 1'b1;

    always_comb begin
        w_state_d      = r_state;
        w_grant_d      = r_grant;
        w_last_grant_d = r_last_grant;
        w_cnt_d        = r_cnt;
        w_pulse_d      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (uart_ready && w_found) begin
                    w_grant_d = w_pick;
                    w_state_d = ST_XFER;
                    w_cnt_d   = '0;
                end
            end
            ST_XFER: begin
                if (w_xfer) begin
                    w_cnt_d = '0;
                    if (req_last[r_grant]) begin
                        w_last_grant_d = r_grant;
                        w_state_d      = ST_IDLE;
                    end
                end else if (!w_own_valid && (TIMEOUT > 0)) begin
                    // Backpressure with valid high never counts toward the stall.
                    w_cnt_d = w_cnt_inc;
                    if (w_cnt_inc == CW'(TIMEOUT)) begin
                        w_last_grant_d = r_grant;
                        w_state_d      = ST_IDLE;
                        w_pulse_d      = 1'b1;
                    end
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge uart_clk or negedge uart_rst) begin
        if (!uart_rst) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_last_grant <= GW'(NUM_REQ - 1);
            r_cnt        <= '0;
            r_pulse      <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_grant      <= w_grant_d;
            r_last_grant <= w_last_grant_d;
            r_cnt        <= w_cnt_d;
            r_pulse      <= w_pulse_d;
        end
    end

    always_comb begin
        req_ready     = '0;
        uart_wr_valid = 1'b0;
        uart_wr_data  = '0;
        if (r_state == ST_XFER) begin
            uart_wr_data       = req_data[{r_grant, 3'b000} +: 8];
            uart_wr_valid      = w_own_valid;
            req_ready[r_grant] = uart_wr_ready;
        end
    end

    assign grant_id      = r_grant;
    assign busy          = (r_state == ST_XFER);
    assign timeout_pulse = r_pulse;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a cycle table for single packets and uart_ready gating,
// plus scripted multi-requester, interleaving, timeout and asynchronous-reset sequences.
module tb_uart_tx_arbiter;

    logic        uart_clk = 1'b0;
    logic        uart_rst = 1'b1;
    logic        uart_ready = 1'b0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_last = '0;
    logic [3:0]  req_ready;
    logic [7:0]  uart_wr_data;
    logic        uart_wr_valid;
    logic        uart_wr_ready = 1'b0;
    logic [1:0]  grant_id;
    logic        busy;
    logic        timeout_pulse;

    int checks = 0;
    int failures = 0;

    uart_tx_arbiter #(
        .NUM_REQ(4),
        .TIMEOUT(16)
    ) dut (
        .uart_clk      (uart_clk),
        .uart_rst      (uart_rst),
        .uart_ready    (uart_ready),
        .req_data      (req_data),
        .req_valid     (req_valid),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .uart_wr_data  (uart_wr_data),
        .uart_wr_valid (uart_wr_valid),
        .uart_wr_ready (uart_wr_ready),
        .grant_id      (grant_id),
        .busy          (busy),
        .timeout_pulse (timeout_pulse)
    );

    always #5 uart_clk = ~uart_clk;

    typedef struct packed {
        logic        ur;
        logic [3:0]  v;
        logic [3:0]  l;
        logic        wr;
        logic [31:0] d;
        logic        e_busy;
        logic [1:0]  e_gid;
        logic        e_wv;
        logic [7:0]  e_wd;
        logic [3:0]  e_rr;
        logic        e_to;
    } vec_t;

    vec_t tbl[13];

    int src_len[4], src_start[4], src_stall[4], src_sent[4];
    int q_cyc[$], q_data[$], q_req[$], q_to[$];
    int e_cyc[$], e_data[$], e_req[$], e_to[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        uart_ready    = 1'b0;
        req_valid     = '0;
        req_last      = '0;
        req_data      = '0;
        uart_wr_ready = 1'b0;
    endtask

    // Leaves the bench at a falling edge with reset released and the DUT idle.
    task automatic do_reset();
        @(negedge uart_clk);
        uart_rst = 1'b0;
        clear_inputs();
        @(posedge uart_clk);
        @(negedge uart_clk);
        uart_rst = 1'b1;
    endtask

    task automatic run_scenario(input int ncycles);
        logic [3:0]  v, l, acc;
        logic [31:0] d;
        int          who;
        for (int i = 0; i < 4; i++) src_sent[i] = 0;
        q_cyc.delete(); q_data.delete(); q_req.delete(); q_to.delete();
        for (int c = 0; c < ncycles; c++) begin
            v = '0; l = '0; d = '0;
            for (int i = 0; i < 4; i++) begin
                if (c >= src_start[i] && src_sent[i] < src_len[i] && src_sent[i] < src_stall[i])
                    v[i] = 1'b1;
                d[8*i +: 8] = 8'(i * 16 + src_sent[i]);
                l[i] = (src_sent[i] == src_len[i] - 1);
            end
            req_valid = v; req_last = l; req_data = d;
            uart_ready = 1'b1; uart_wr_ready = 1'b1;
            #1;
            acc = req_valid & req_ready;
            if (uart_wr_valid && uart_wr_ready) begin
                who = -1;
                if ($countones(acc) == 1)
                    for (int i = 0; i < 4; i++) if (acc[i]) who = i;
                q_cyc.push_back(c); q_data.push_back(int'(uart_wr_data)); q_req.push_back(who);
            end
            if (timeout_pulse) q_to.push_back(c);
            @(posedge uart_clk);
            for (int i = 0; i < 4; i++) if (acc[i]) src_sent[i]++;
            @(negedge uart_clk);
        end
    endtask

    task automatic cmp_scenario(input string tag);
        chk({tag, " xfer_count"}, q_cyc.size(), e_cyc.size());
        for (int k = 0; k < e_cyc.size(); k++) begin
            if (k < q_cyc.size()) begin
                chk($sformatf("%s xfer%0d cycle", tag, k), q_cyc[k], e_cyc[k]);
                chk($sformatf("%s xfer%0d data", tag, k), q_data[k], e_data[k]);
                chk($sformatf("%s xfer%0d req", tag, k), q_req[k], e_req[k]);
            end
        end
        chk({tag, " pulse_count"}, q_to.size(), e_to.size());
        for (int k = 0; k < e_to.size(); k++)
            if (k < q_to.size()) chk($sformatf("%s pulse%0d cycle", tag, k), q_to[k], e_to[k]);
    endtask

    initial begin
        //            ur  v        l        wr  data          busy gid wv wd     rr       to
        tbl[0]  = '{1'b1, 4'b0010, 4'b0000, 1'b1, 32'h0000_4100, 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000, 1'b0};
        tbl[1]  = '{1'b1, 4'b0010, 4'b0000, 1'b1, 32'h0000_4100, 1'b1, 2'd1, 1'b1, 8'h41, 4'b0010, 1'b0};
        tbl[2]  = '{1'b1, 4'b0010, 4'b0000, 1'b1, 32'h0000_4200, 1'b1, 2'd1, 1'b1, 8'h42, 4'b0010, 1'b0};
        tbl[3]  = '{1'b1, 4'b0010, 4'b0010, 1'b1, 32'h0000_4300, 1'b1, 2'd1, 1'b1, 8'h43, 4'b0010, 1'b0};
        tbl[4]  = '{1'b1, 4'b0000, 4'b0000, 1'b1, 32'h0000_0000, 1'b0, 2'd1, 1'b0, 8'h00, 4'b0000, 1'b0};
        tbl[5]  = '{1'b0, 4'b1001, 4'b1001, 1'b1, 32'h7700_0055, 1'b0, 2'd1, 1'b0, 8'h00, 4'b0000, 1'b0};
        tbl[6]  = '{1'b0, 4'b1001, 4'b1001, 1'b1, 32'h7700_0055, 1'b0, 2'd1, 1'b0, 8'h00, 4'b0000, 1'b0};
        tbl[7]  = '{1'b1, 4'b1001, 4'b1001, 1'b1, 32'h7700_0055, 1'b0, 2'd1, 1'b0, 8'h00, 4'b0000, 1'b0};
        tbl[8]  = '{1'b0, 4'b1001, 4'b1001, 1'b0, 32'h7700_0055, 1'b1, 2'd3, 1'b1, 8'h77, 4'b0000, 1'b0};
        tbl[9]  = '{1'b0, 4'b1001, 4'b1001, 1'b1, 32'h7700_0055, 1'b1, 2'd3, 1'b1, 8'h77, 4'b1000, 1'b0};
        tbl[10] = '{1'b1, 4'b0001, 4'b0001, 1'b1, 32'h0000_0055, 1'b0, 2'd3, 1'b0, 8'h00, 4'b0000, 1'b0};
        tbl[11] = '{1'b1, 4'b0001, 4'b0001, 1'b1, 32'h0000_0055, 1'b1, 2'd0, 1'b1, 8'h55, 4'b0001, 1'b0};
        tbl[12] = '{1'b1, 4'b0000, 4'b0000, 1'b1, 32'h0000_0000, 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000, 1'b0};

        #2 uart_rst = 1'b0;
        #1;
        chk("reset busy", busy, 0);
        chk("reset gid", grant_id, 0);
        chk("reset wr_valid", uart_wr_valid, 0);
        chk("reset wr_data", uart_wr_data, 0);
        chk("reset req_ready", req_ready, 0);
        chk("reset pulse", timeout_pulse, 0);
        @(posedge uart_clk);
        @(negedge uart_clk);
        uart_rst = 1'b1;

        // Single packet from requester 1, then uart_ready gating and backpressure.
        for (int n = 0; n < 13; n++) begin
            uart_ready = tbl[n].ur; req_valid = tbl[n].v; req_last = tbl[n].l;
            uart_wr_ready = tbl[n].wr; req_data = tbl[n].d;
            #1;
            chk($sformatf("vec%0d busy", n), busy, tbl[n].e_busy);
            chk($sformatf("vec%0d gid", n), grant_id, tbl[n].e_gid);
            chk($sformatf("vec%0d wr_valid", n), uart_wr_valid, tbl[n].e_wv);
            chk($sformatf("vec%0d wr_data", n), uart_wr_data, tbl[n].e_wd);
            chk($sformatf("vec%0d req_ready", n), req_ready, tbl[n].e_rr);
            chk($sformatf("vec%0d pulse", n), timeout_pulse, tbl[n].e_to);
            @(posedge uart_clk);
            @(negedge uart_clk);
        end

        // All four requesters with 2-byte packets: order 0,1,2,3 with one idle cycle between.
        do_reset();
        src_len = '{2, 2, 2, 2}; src_start = '{0, 0, 0, 0}; src_stall = '{99, 99, 99, 99};
        run_scenario(14);
        e_cyc  = '{1, 2, 4, 5, 7, 8, 10, 11};
        e_data = '{'h00, 'h01, 'h10, 'h11, 'h20, 'h21, 'h30, 'h31};
        e_req  = '{0, 0, 1, 1, 2, 2, 3, 3};
        e_to.delete();
        cmp_scenario("rr4");

        // Requester 0 raises valid mid-packet of requester 2: no interleaving.
        do_reset();
        src_len = '{1, 0, 4, 0}; src_start = '{2, 0, 0, 0}; src_stall = '{99, 99, 99, 99};
        run_scenario(9);
        e_cyc  = '{1, 2, 3, 4, 6};
        e_data = '{'h20, 'h21, 'h22, 'h23, 'h00};
        e_req  = '{2, 2, 2, 2, 0};
        e_to.delete();
        cmp_scenario("lock");

        // Owner 1 stalls after one byte; 16 idle cycles revoke it, then requester 2 is served.
        do_reset();
        src_len = '{0, 3, 1, 0}; src_start = '{0, 0, 0, 0}; src_stall = '{99, 1, 99, 99};
        run_scenario(22);
        e_cyc  = '{1, 19};
        e_data = '{'h10, 'h20};
        e_req  = '{1, 2};
        e_to   = '{18};
        cmp_scenario("timeout");

        // Asynchronous reset between edges mid-packet.
        do_reset();
        uart_ready = 1'b1; uart_wr_ready = 1'b1;
        req_valid = 4'b1000; req_last = 4'b0000; req_data = 32'h9900_0000;
        @(posedge uart_clk);
        @(negedge uart_clk);
        chk("arst pre busy", busy, 1);
        chk("arst pre wr_data", uart_wr_data, 'h99);
        #2 uart_rst = 1'b0;
        #1;
        chk("arst busy", busy, 0);
        chk("arst wr_valid", uart_wr_valid, 0);
        chk("arst wr_data", uart_wr_data, 0);
        chk("arst req_ready", req_ready, 0);
        chk("arst gid", grant_id, 0);
        @(posedge uart_clk);
        @(negedge uart_clk);
        uart_rst = 1'b1;
        req_valid = 4'b1001; req_last = 4'b1001; req_data = 32'h9900_0055;
        @(posedge uart_clk);
        #1;
        chk("arst post gid", grant_id, 0);
        chk("arst post busy", busy, 1);
        chk("arst post wr_data", uart_wr_data, 'h55);
        chk("arst post req_ready", req_ready, 4'b0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
